// File: rtl/upstream_risk_engine.sv
// ---------------------------------------------------------------------------
// upstream_risk_engine
//
// Pre-trade risk checker. It keeps a per-client table of max-to-trade,
// accumulated (booked) amount and cancelled amount. Each order goes through
// IDLE -> LOOKUP -> DECIDE. In DECIDE the order's net exposure is computed
// from the live table and compared against the client's max. An accepted
// order is booked into its client's accumulated total.
//
// Ports
//   clk, HRESETn            clock, asynchronous active-low reset
//   ord_valid/ord_ready     order handshake (ready only in IDLE)
//   ord_client_id/amount    order payload, latched on the handshake
//   max_valid/client/value  max-to-trade overwrite strobe (any state)
//   cxl_valid/client/amount cancel strobe, added to the cancelled total
//   dec_valid               one-cycle decision pulse
//   dec_accept              order passed and was booked
//   dec_client_id           client of the decided order (held)
//   dec_exposure            net exposure used for the decision (held)
//   rej_count               saturating count of rejected orders
// ---------------------------------------------------------------------------
module upstream_risk_engine #(
   parameter int N_CLIENTS = 32,
   parameter int ID_W      = 5,
   parameter int AMT_W     = 16,
   parameter int ACC_W     = 32
) (
   input  logic             clk,
   input  logic             HRESETn,
   input  logic             ord_valid,
   output logic             ord_ready,
   input  logic [ID_W-1:0]  ord_client_id,
   input  logic [AMT_W-1:0] ord_amount,
   input  logic             max_valid,
   input  logic [ID_W-1:0]  max_client_id,
   input  logic [ACC_W-1:0] max_value,
   input  logic             cxl_valid,
   input  logic [ID_W-1:0]  cxl_client_id,
   input  logic [AMT_W-1:0] cxl_amount,
   output logic             dec_valid,
   output logic             dec_accept,
   output logic [ID_W-1:0]  dec_client_id,
   output logic [ACC_W-1:0] dec_exposure,
   output logic [15:0]      rej_count
);

   localparam logic [ACC_W-1:0] ACC_SAT = {ACC_W{1'b1}};
   localparam logic [15:0]      REJ_SAT = 16'hFFFF;
   localparam logic [ID_W:0]    N_LIMIT = (ID_W+1)'(N_CLIENTS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      DECIDE = 2'd2
   } state_t;

   // Saturating add of an amount onto a wide total.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] base,
                                                input logic [AMT_W-1:0] inc);
      logic [ACC_W:0] sum;
      sum = {1'b0, base} + {{(ACC_W+1-AMT_W){1'b0}}, inc};
      if (sum[ACC_W]) begin
         sat_add = ACC_SAT;
      end else begin
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             ord_ready_r;
   logic [ID_W-1:0]  ord_id_r;
   logic [AMT_W-1:0] ord_amt_r;

   logic [ACC_W-1:0] max_r [N_CLIENTS];
   logic [ACC_W-1:0] acc_r [N_CLIENTS];
   logic [ACC_W-1:0] cxl_r [N_CLIENTS];

   logic             take_s;
   logic             id_ok_s;
   logic [ACC_W-1:0] max_rd_s;
   logic [ACC_W-1:0] acc_rd_s;
   logic [ACC_W-1:0] cxl_rd_s;
   logic [ACC_W:0]   gross_s;
   logic [ACC_W:0]   net_s;
   logic             accept_s;
   logic             book_s;
   logic [ACC_W-1:0] exposure_s;

   logic             dec_valid_r;
   logic             dec_accept_r;
   logic [ID_W-1:0]  dec_client_id_r;
   logic [ACC_W-1:0] dec_exposure_r;
   logic [15:0]      rej_count_r;

   assign take_s        = ord_valid && (state_r == IDLE);
   assign ord_ready     = ord_ready_r;
   assign dec_valid     = dec_valid_r;
   assign dec_accept    = dec_accept_r;
   assign dec_client_id = dec_client_id_r;
   assign dec_exposure  = dec_exposure_r;
   assign rej_count     = rej_count_r;

   // Next-state logic for the order FSM.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (ord_valid) begin
               next_state_s = LOOKUP;
            end else begin
               next_state_s = IDLE;
            end
         end
         LOOKUP:  next_state_s = DECIDE;
         DECIDE:  next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register; ready is registered from the next state so it is high exactly in IDLE.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r     <= IDLE;
         ord_ready_r <= 1'b1;
      end else begin
         state_r     <= next_state_s;
         ord_ready_r <= (next_state_s == IDLE);
      end
   end

   // Order payload latch, loaded on the handshake.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         ord_id_r  <= {ID_W{1'b0}};
         ord_amt_r <= {AMT_W{1'b0}};
      end else if (take_s) begin
         ord_id_r  <= ord_client_id;
         ord_amt_r <= ord_amount;
      end
   end

   // Table read for the pending order; out-of-range ids read as an empty entry.
   always_comb begin
      id_ok_s  = ({1'b0, ord_id_r} < N_LIMIT);
      max_rd_s = {ACC_W{1'b0}};
      acc_rd_s = {ACC_W{1'b0}};
      cxl_rd_s = {ACC_W{1'b0}};
      if (id_ok_s) begin
         max_rd_s = max_r[ord_id_r];
         acc_rd_s = acc_r[ord_id_r];
         cxl_rd_s = cxl_r[ord_id_r];
      end else begin
         max_rd_s = {ACC_W{1'b0}};
         acc_rd_s = {ACC_W{1'b0}};
         cxl_rd_s = {ACC_W{1'b0}};
      end
   end

   // Net exposure: the negative clamp is done by comparing before subtracting,
   // so the unsigned difference never wraps.
   always_comb begin
      gross_s = {1'b0, acc_rd_s} + {{(ACC_W+1-AMT_W){1'b0}}, ord_amt_r};
      if (gross_s > {1'b0, cxl_rd_s}) begin
         net_s = gross_s - {1'b0, cxl_rd_s};
      end else begin
         net_s = {(ACC_W+1){1'b0}};
      end
      accept_s   = id_ok_s && (net_s < {1'b0, max_rd_s});
      exposure_s = net_s[ACC_W] ? ACC_SAT : net_s[ACC_W-1:0];
      book_s     = (state_r == DECIDE) && accept_s;
   end

   // Client table: max, cancel and booking target separate fields and may all land together.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            max_r[i] <= {ACC_W{1'b0}};
            acc_r[i] <= {ACC_W{1'b0}};
            cxl_r[i] <= {ACC_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            if (max_valid && (max_client_id == ID_W'(i))) begin
               max_r[i] <= max_value;
            end
            if (cxl_valid && (cxl_client_id == ID_W'(i))) begin
               cxl_r[i] <= sat_add(cxl_r[i], cxl_amount);
            end
            if (book_s && (ord_id_r == ID_W'(i))) begin
               acc_r[i] <= sat_add(acc_r[i], ord_amt_r);
            end
         end
      end
   end

   // Decision outputs, registered at the end of DECIDE; id and exposure hold until the next one.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         dec_valid_r     <= 1'b0;
         dec_accept_r    <= 1'b0;
         dec_client_id_r <= {ID_W{1'b0}};
         dec_exposure_r  <= {ACC_W{1'b0}};
         rej_count_r     <= 16'd0;
      end else begin
         dec_valid_r <= (state_r == DECIDE);
         if (state_r == DECIDE) begin
            dec_accept_r    <= accept_s;
            dec_client_id_r <= ord_id_r;
            dec_exposure_r  <= exposure_s;
            if (!accept_s && (rej_count_r != REJ_SAT)) begin
               rej_count_r <= rej_count_r + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_upstream_risk_engine.sv
module tb_upstream_risk_engine;

   localparam int     NC  = 20;
   localparam int     IDW = 5;
   localparam int     AW  = 16;
   localparam int     CW  = 32;
   localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

   logic           clk = 1'b0;
   logic           HRESETn;
   logic           ord_valid;
   logic           ord_ready;
   logic [IDW-1:0] ord_client_id;
   logic [AW-1:0]  ord_amount;
   logic           max_valid;
   logic [IDW-1:0] max_client_id;
   logic [CW-1:0]  max_value;
   logic           cxl_valid;
   logic [IDW-1:0] cxl_client_id;
   logic [AW-1:0]  cxl_amount;
   logic           dec_valid;
   logic           dec_accept;
   logic [IDW-1:0] dec_client_id;
   logic [CW-1:0]  dec_exposure;
   logic [15:0]    rej_count;

   always #5 clk = ~clk;

   upstream_risk_engine #(.N_CLIENTS(NC), .ID_W(IDW), .AMT_W(AW), .ACC_W(CW)) dut (
      .clk(clk), .HRESETn(HRESETn),
      .ord_valid(ord_valid), .ord_ready(ord_ready),
      .ord_client_id(ord_client_id), .ord_amount(ord_amount),
      .max_valid(max_valid), .max_client_id(max_client_id), .max_value(max_value),
      .cxl_valid(cxl_valid), .cxl_client_id(cxl_client_id), .cxl_amount(cxl_amount),
      .dec_valid(dec_valid), .dec_accept(dec_accept), .dec_client_id(dec_client_id),
      .dec_exposure(dec_exposure), .rej_count(rej_count)
   );

   // Reference model: the client table as plain integers plus the pending order.
   longint     m_max [32];
   longint     m_acc [32];
   longint     m_cxl [32];
   int         m_rej;
   int         busy;       // edges left until the pending order is decided
   logic [4:0] p_id;
   longint     p_amt;
   bit         e_valid;
   bit         e_accept;
   logic [4:0] e_cid;
   longint     e_exp;
   bit         e_exp_known;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit         do_max;
      logic [4:0] max_id;
      longint     max_val;
      bit         do_cxl;
      logic [4:0] cxl_id;
      longint     cxl_amt;
      logic [4:0] id;
      longint     amt;
      bit         acc;
      longint     expo;
      bit         chk_expo;
      int         rej;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_max[i] = 0;
         m_acc[i] = 0;
         m_cxl[i] = 0;
      end
      m_rej = 0; busy = 0; p_id = 5'd0; p_amt = 0;
      e_valid = 1'b0; e_accept = 1'b0; e_cid = 5'd0; e_exp = 0; e_exp_known = 1'b1;
   endtask

   task automatic idle_inputs();
      ord_valid = 1'b0; ord_client_id = 5'd0; ord_amount = 16'd0;
      max_valid = 1'b0; max_client_id = 5'd0; max_value = 32'd0;
      cxl_valid = 1'b0; cxl_client_id = 5'd0; cxl_amount = 16'd0;
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1 HRESETn = 1'b1;
   endtask

   // One clock: capture inputs, advance the model at the edge, then compare all outputs.
   task automatic cycle();
      bit         decide;
      bit         take;
      longint     net;
      bit         mval;
      bit         cval;
      bit         oval;
      logic [4:0] mid;
      logic [4:0] cid;
      logic [4:0] oid;
      longint     mv;
      longint     ca;
      longint     oa;
      mval = max_valid; mid = max_client_id; mv = longint'({32'd0, max_value});
      cval = cxl_valid; cid = cxl_client_id; ca = longint'({48'd0, cxl_amount});
      oval = ord_valid; oid = ord_client_id; oa = longint'({48'd0, ord_amount});
      @(posedge clk);
      decide  = (busy == 1);
      take    = (busy == 0) && oval;
      e_valid = decide;
      if (decide) begin
         e_cid = p_id;
         if (p_id < NC) begin
            net = m_acc[p_id] + p_amt - m_cxl[p_id];
            if (net < 0) net = 0;
            e_exp       = (net > SAT) ? SAT : net;
            e_exp_known = 1'b1;
            e_accept    = (net < m_max[p_id]);
         end else begin
            e_exp_known = 1'b0;
            e_accept    = 1'b0;
         end
         if (e_accept) begin
            m_acc[p_id] = (m_acc[p_id] + p_amt > SAT) ? SAT : m_acc[p_id] + p_amt;
         end else if (m_rej < 65535) begin
            m_rej++;
         end
      end
      if (mval && mid < NC) m_max[mid] = mv;
      if (cval && cid < NC) m_cxl[cid] = (m_cxl[cid] + ca > SAT) ? SAT : m_cxl[cid] + ca;
      if (take) begin
         p_id = oid; p_amt = oa; busy = 2;
      end else if (busy > 0) begin
         busy--;
      end
      #1;
      chk("dec_valid", longint'(dec_valid), longint'(e_valid));
      chk("ord_ready", longint'(ord_ready), longint'(busy == 0));
      chk("rej_count", longint'(rej_count), longint'(m_rej));
      chk("dec_client_id", longint'(dec_client_id), longint'(e_cid));
      if (e_exp_known) chk("dec_exposure", longint'({32'd0, dec_exposure}), e_exp);
      if (decide) chk("dec_accept", longint'(dec_accept), longint'(e_accept));
   endtask

   // Optional strobes in one cycle, then a single order through to its decision.
   task automatic run_vec(input vec_t v, input int n);
      max_valid = v.do_max; max_client_id = v.max_id; max_value = 32'(v.max_val);
      cxl_valid = v.do_cxl; cxl_client_id = v.cxl_id; cxl_amount = 16'(v.cxl_amt);
      cycle();
      idle_inputs();
      ord_valid = 1'b1; ord_client_id = v.id; ord_amount = 16'(v.amt);
      cycle();
      ord_valid = 1'b0;
      cycle();
      cycle();
      chk($sformatf("vec%0d_valid", n), longint'(dec_valid), 1);
      chk($sformatf("vec%0d_accept", n), longint'(dec_accept), longint'(v.acc));
      if (v.chk_expo) chk($sformatf("vec%0d_exposure", n), longint'({32'd0, dec_exposure}), v.expo);
      chk($sformatf("vec%0d_rej", n), longint'(rej_count), longint'(v.rej));
   endtask

   initial begin
      int   ndec;
      vec_t v;
      //          max strobe      cancel strobe    order     acc expo chk rej
      vt[0]  = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd3,  10,  1'b0, 10,   1'b1, 1};
      vt[1]  = '{1'b1, 5'd3,  100,  1'b0, 5'd0,  0,   5'd3,  60,  1'b1, 60,   1'b1, 1};
      vt[2]  = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd3,  39,  1'b1, 99,   1'b1, 1};
      vt[3]  = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd3,  1,   1'b0, 100,  1'b1, 2};
      vt[4]  = '{1'b0, 5'd0,  0,    1'b1, 5'd3,  50,  5'd3,  40,  1'b1, 89,   1'b1, 2};
      vt[5]  = '{1'b1, 5'd7,  5,    1'b1, 5'd7,  200, 5'd7,  100, 1'b1, 0,    1'b1, 2};
      vt[6]  = '{1'b1, 5'd31, 500,  1'b0, 5'd0,  0,   5'd31, 5,   1'b0, 0,    1'b0, 3};
      vt[7]  = '{1'b1, 5'd19, 1000, 1'b0, 5'd0,  0,   5'd19, 999, 1'b1, 999,  1'b1, 3};
      vt[8]  = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd19, 1,   1'b0, 1000, 1'b1, 4};
      vt[9]  = '{1'b0, 5'd0,  0,    1'b1, 5'd20, 100, 5'd20, 7,   1'b0, 0,    1'b0, 5};
      vt[10] = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd3,  11,  1'b0, 100,  1'b1, 6};
      vt[11] = '{1'b0, 5'd0,  0,    1'b0, 5'd0,  0,   5'd0,  0,   1'b0, 0,    1'b1, 7};

      do_reset();
      cycle();
      chk("reset_ready", longint'(ord_ready), 1);
      chk("reset_rej", longint'(rej_count), 0);

      for (int i = 0; i < 12; i++) run_vec(vt[i], i);

      // Max strobe on the LOOKUP edge is seen by the decision.
      max_valid = 1'b1; max_client_id = 5'd5; max_value = 32'd100;
      cycle();
      idle_inputs(); ord_valid = 1'b1; ord_client_id = 5'd5; ord_amount = 16'd1;
      cycle();
      idle_inputs(); max_valid = 1'b1; max_client_id = 5'd5; max_value = 32'd0;
      cycle();
      idle_inputs();
      cycle();
      chk("lookup_strobe_accept", longint'(dec_accept), 0);

      // Max strobe on the DECIDE edge is not seen, but the next order sees it.
      max_valid = 1'b1; max_client_id = 5'd5; max_value = 32'd100;
      cycle();
      idle_inputs(); ord_valid = 1'b1; ord_client_id = 5'd5; ord_amount = 16'd1;
      cycle();
      idle_inputs();
      cycle();
      max_valid = 1'b1; max_client_id = 5'd5; max_value = 32'd0;
      cycle();
      chk("decide_strobe_accept", longint'(dec_accept), 1);
      chk("decide_strobe_expo", longint'({32'd0, dec_exposure}), 1);
      idle_inputs(); ord_valid = 1'b1; ord_client_id = 5'd5; ord_amount = 16'd1;
      cycle();
      idle_inputs();
      cycle();
      cycle();
      chk("after_strobe_accept", longint'(dec_accept), 0);
      chk("after_strobe_expo", longint'({32'd0, dec_exposure}), 2);

      // Back-to-back orders with ord_valid held high.
      max_valid = 1'b1; max_client_id = 5'd4; max_value = 32'd1000;
      cycle();
      idle_inputs(); ord_valid = 1'b1; ord_client_id = 5'd4; ord_amount = 16'd1;
      ndec = 0;
      for (int k = 0; k < 9; k++) begin
         cycle();
         if (dec_valid) ndec++;
      end
      chk("b2b_decisions", longint'(ndec), 3);
      idle_inputs(); ord_valid = 1'b1; ord_client_id = 5'd4; ord_amount = 16'd0;
      cycle();
      idle_inputs();
      cycle();
      cycle();
      chk("b2b_booked", longint'({32'd0, dec_exposure}), 3);

      // Reset while an order sits in LOOKUP.
      ord_valid = 1'b1; ord_client_id = 5'd3; ord_amount = 16'd5;
      cycle();
      do_reset();
      for (int k = 0; k < 4; k++) cycle();
      chk("rst_lookup_ready", longint'(ord_ready), 1);
      chk("rst_lookup_rej", longint'(rej_count), 0);
      v = '{1'b0, 5'd0, 0, 1'b0, 5'd0, 0, 5'd3, 10, 1'b0, 10, 1'b1, 1};
      run_vec(v, 99);

      // Randomised traffic against the model.
      for (int k = 0; k < 600; k++) begin
         if (!(ord_valid && busy != 0)) begin
            ord_valid     = ($urandom_range(0, 2) == 0);
            ord_client_id = 5'($urandom_range(0, 31));
            ord_amount    = 16'($urandom_range(0, 400));
         end
         max_valid     = ($urandom_range(0, 7) == 0);
         max_client_id = 5'($urandom_range(0, 31));
         max_value     = 32'($urandom_range(0, 3000));
         cxl_valid     = ($urandom_range(0, 7) == 0);
         cxl_client_id = 5'($urandom_range(0, 31));
         cxl_amount    = 16'($urandom_range(0, 300));
         cycle();
      end
      idle_inputs();
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
